mux_4x1_rr: RTL

- Four-channel round-robin collector, the inverse of demux_2x4.
- Merges four valid/ready input streams onto one registered output stream.
- Each output beat carries a 2-bit channel tag. out_sel drives the select input of a downstream demux_2x4 directly, so the original source channel is restored at the far end.
- Sits between per-channel producers and a shared single-lane link.

---
 rtl/mux_4x1_rr_if.sv | 34 +++
 rtl/mux_4x1_rr.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_4x1_rr_if.sv
// Bundle of the four-channel input streams and the single tagged output
// stream of the round-robin collector. The slave view is the collector
// itself; the master view is whatever drives producers and sinks around it.
interface mux_4x1_rr_if #(
    parameter int WIDTH = 1
);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/mux_4x1_rr.sv
// Four-channel round-robin collector. Merges four valid/ready streams into
// one registered output slot; each beat is tagged with its source channel
// (out_sel) so a downstream 2-to-4 demux can restore the original lane.
// The slot accepts a new beat whenever it is empty or being drained in the
// same cycle, giving one beat per cycle with a one-cycle latency.
module mux_4x1_rr #(
    parameter int WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_4x1_rr_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    slot_state_e       state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [1:0]        out_sel_q, out_sel_d;
    logic [1:0]        ptr_q, ptr_d;

    logic              slot_free_s;
    logic              gnt_found_s;
    logic [1:0]        gnt_idx_s;
    logic [1:0]        scan_idx_s;
    logic [3:0]        gnt_onehot_s;
    logic              gnt_valid_s;
    logic [WIDTH-1:0]  gnt_data_s;

    // Slot can take a beat when it is empty or its beat leaves this cycle.
    always_comb begin
        slot_free_s = (!out_valid_q) || bus.out_ready;
    end

    // Scan channels starting at the priority pointer; first requester wins.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = 2'd0;
        scan_idx_s  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx_s = ptr_q + 2'(k);
            if (!gnt_found_s && bus.in_valid[scan_idx_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = scan_idx_s;
            end else begin
                gnt_found_s = gnt_found_s;
                gnt_idx_s   = gnt_idx_s;
            end
        end
    end

    // One-hot grant, forced to zero while reset is held or the slot is busy.
    always_comb begin
        gnt_onehot_s = 4'b0000;
        if (rst_n && slot_free_s && gnt_found_s) begin
            gnt_onehot_s = 4'b0001 << gnt_idx_s;
        end else begin
            gnt_onehot_s = 4'b0000;
        end
        gnt_valid_s = |gnt_onehot_s;
    end

    // Pick the data word of the granted channel.
    always_comb begin
        gnt_data_s = {WIDTH{1'b0}};
        case (gnt_idx_s)
            2'd0:    gnt_data_s = bus.in_data[0*WIDTH +: WIDTH];
            2'd1:    gnt_data_s = bus.in_data[1*WIDTH +: WIDTH];
            2'd2:    gnt_data_s = bus.in_data[2*WIDTH +: WIDTH];
            2'd3:    gnt_data_s = bus.in_data[3*WIDTH +: WIDTH];
            default: gnt_data_s = {WIDTH{1'b0}};
        endcase
    end

    // Slot state transitions, payload capture and pointer advance.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;

        case (state_q)
            ST_EMPTY: begin
                if (gnt_valid_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    // Drain; a simultaneous grant keeps the slot full.
                    if (gnt_valid_s) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (gnt_valid_s) begin
            out_data_d = gnt_data_s;
            out_sel_d  = gnt_idx_s;
            ptr_d      = gnt_idx_s + 2'd1;
        end else begin
            // Stall or drain: last payload and pointer are simply kept.
            out_data_d = out_data_q;
            out_sel_d  = out_sel_q;
            ptr_d      = ptr_q;
        end

        out_valid_d = (state_d == ST_FULL);
    end

    // Output slot and priority pointer registers; reset discards any beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_sel_q   <= 2'd0;
            ptr_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = gnt_onehot_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule
